// File: rtl/instr_encoder_loader.sv
// Field-level RV32I instruction encoder that streams packed words into IMEM.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [2:0] FMT_R      = 3'd0;
  localparam logic [2:0] FMT_LOAD   = 3'd1;
  localparam logic [2:0] FMT_STORE  = 3'd2;
  localparam logic [2:0] FMT_BRANCH = 3'd3;
  localparam logic [2:0] FMT_IMM    = 3'd4;
  localparam logic [2:0] FMT_END    = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);

  function automatic logic [31:0] encode(input logic [2:0] fmt, input logic [2:0] f3,
                                         input logic f7b5, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic signed [12:0] imm);
    logic [31:0] w;
    w = '0;
    case (fmt)
      FMT_R:      w = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, OP_R};
      FMT_LOAD:   w = {imm[11:0], rs1, f3, rd, OP_LOAD};
      FMT_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      FMT_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      FMT_IMM: begin
        // SRLI/SRAI: the upper immediate bits carry only the arithmetic-shift flag
        if (f3 == 3'b101) w = {1'b0, f7b5, 5'b0, imm[4:0], rs1, f3, rd, OP_IMM};
        else              w = {imm[11:0], rs1, f3, rd, OP_IMM};
      end
      default:    w = '0;
    endcase
    return w;
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  function automatic logic imm_illegal(input logic [2:0] fmt, input logic [2:0] f3,
                                       input logic signed [12:0] imm);
    logic bad;
    bad = 1'b0;
    if (fmt == FMT_BRANCH) bad = imm[0];
    else if (fmt == FMT_LOAD || fmt == FMT_STORE || fmt == FMT_IMM) begin
      bad = (imm[12] != imm[11]);
      if (fmt == FMT_IMM && (f3 == 3'b001 || f3 == 3'b101) && imm[11:5] != 7'd0)
        bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  logic [2:0] state;
  logic       fmt_word;
  logic       overflow;
  logic       bad_imm;

  assign fmt_word = (in_fmt <= FMT_IMM);
  assign overflow = (word_count >= DEPTH_W);
`ifdef IMM_RANGE_CHECK_EN
  assign bad_imm  = imm_illegal(in_fmt, in_funct3, in_imm);
`else
  assign bad_imm  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      imem_addr  <= BASE;
      word_count <= '0;
      imem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_ACCEPT;
            imem_addr  <= BASE;
            word_count <= '0;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            if (in_fmt == FMT_END)                     state <= S_DONE;
            else if (!fmt_word || overflow || bad_imm) state <= S_ERR;
            else begin
              imem_wdata <= encode(in_fmt, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm);
              state      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (imem_ready) begin
            imem_addr  <= imem_addr + 1'b1;
            word_count <= word_count + 1'b1;
            state      <= S_ACCEPT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // All status outputs decode directly from the registered state
  assign in_ready = (state == S_ACCEPT);
  assign busy     = (state == S_ACCEPT) || (state == S_WRITE);
  assign imem_we  = (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader with a queue-based reference model.
module tb_instr_encoder_loader;
  localparam int AW  = 8;
  localparam int DEP = 4;
  localparam int BA  = 0;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, in_valid = 1'b0, imem_ready = 1'b0;
  logic [2:0] in_fmt = '0, in_funct3 = '0;
  logic in_f7b5 = 1'b0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [12:0] in_imm = '0;
  logic in_ready, imem_we, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] word_count;

  instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DEP), .BASE_ADDR(BA)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
    .word_count(word_count), .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  // reference model state
  int unsigned qa[$];
  int unsigned qd[$];
  bit exp_busy = 0, exp_done = 0, exp_err = 0;
  int exp_count = 0, sess_words = 0, next_addr = BA;
  bit chk_en = 0, rand_rdy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int unsigned model_enc(int unsigned fmt, int unsigned f3, int unsigned f7,
                                            int unsigned rd, int unsigned rs1, int unsigned rs2,
                                            int unsigned imm13);
    int unsigned w, i12;
    i12 = imm13 & 'hFFF;
    w = 0;
    case (fmt)
      0: w = 'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 30);
      1: w = 'h03 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (i12 << 20);
      2: w = 'h23 | ((i12 & 'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | ((i12 >> 5) << 25);
      3: w = 'h63 | (((imm13 >> 11) & 1) << 7) | (((imm13 >> 1) & 'hF) << 8) | (f3 << 12)
             | (rs1 << 15) | (rs2 << 20) | (((imm13 >> 5) & 'h3F) << 25) | (((imm13 >> 12) & 1) << 31);
      4: begin
        w = 'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (i12 << 20);
        if (f3 == 5) w = (w & 'h01FF_FFFF) | (f7 << 30);
      end
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bit range_bad(int unsigned fmt, int unsigned f3, int unsigned imm13);
    bit bad = 0;
`ifdef IMM_RANGE_CHECK_EN
    int sv;
    sv = (imm13 >= 4096) ? int'(imm13) - 8192 : int'(imm13);
    if (fmt == 3) bad = (imm13 % 2) == 1;
    if ((fmt == 1 || fmt == 2 || fmt == 4) && (sv < -2048 || sv > 2047)) bad = 1;
    if (fmt == 4 && (f3 == 1 || f3 == 5) && ((imm13 >> 5) & 'h7F) != 0) bad = 1;
`endif
    return bad;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("error", error, exp_err);
      check("in_ready", in_ready, exp_busy && qd.size() == 0);
      check("imem_we", imem_we, qd.size() > 0);
      check("word_count", word_count, exp_count);
      if (imem_we && qd.size() > 0) begin
        check("imem_addr", imem_addr, qa[0]);
        check("imem_wdata", imem_wdata, qd[0]);
        if (imem_ready) begin
          void'(qa.pop_front());
          void'(qd.pop_front());
          exp_count++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) imem_ready = ($urandom_range(0, 9) < 7);
  end

  task automatic model_clear();
    qa.delete(); qd.delete();
    exp_busy = 0; exp_done = 0; exp_err = 0;
    exp_count = 0; sess_words = 0; next_addr = BA;
  endtask

  task automatic do_reset();
    reset = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
  endtask

  task automatic start_session();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    model_clear();
    exp_busy = 1;
  endtask

  task automatic send(int unsigned fmt, int unsigned f3, int unsigned f7, int unsigned rd,
                      int unsigned rs1, int unsigned rs2, int unsigned imm13);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      in_fmt = 3'(fmt); in_funct3 = 3'(f3); in_f7b5 = f7[0];
      in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 13'(imm13);
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      if (fmt == 7) begin exp_busy = 0; exp_done = 1; end
      else if (fmt > 4 || sess_words == DEP || range_bad(fmt, f3, imm13)) begin
        exp_busy = 0; exp_err = 1;
      end else begin
        qa.push_back(int'(next_addr));
        qd.push_back(model_enc(fmt, f3, f7, rd, rs1, rs2, imm13));
        sess_words++;
        next_addr = (next_addr + 1) % (1 << AW);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (qd.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (qd.size() > 0) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, BA);
    check("rst_wdata", imem_wdata, 0);
    check("rst_count", word_count, 0);
    check("rst_flags", {in_ready, busy, done, error}, 0);
    chk_en = 1;

    check("model_R", model_enc(0, 0, 0, 3, 1, 2, 0), 32'h002081B3);
    check("model_LOAD", model_enc(1, 2, 0, 5, 0, 0, 8), 32'h00802283);
    check("model_STORE", model_enc(2, 2, 0, 0, 0, 5, 12), 32'h00502623);
    check("model_IMM", model_enc(4, 0, 0, 1, 0, 0, 5), 32'h00500093);
    check("model_BRANCH", model_enc(3, 0, 0, 0, 1, 2, 'h1FFC), 32'hFE208EE3);
    check("model_SRAI", model_enc(4, 5, 1, 1, 2, 0, 'h3), 32'h40315093);

    // single R-type word
    start_session(); imem_ready = 1;
    send(0, 0, 0, 3, 1, 2, 0);
    @(negedge clk);
    check("r_we", imem_we, 1); check("r_addr", imem_addr, 0); check("r_wdata", imem_wdata, 32'h002081B3);
    @(posedge clk); #1; @(negedge clk);
    check("r_count", word_count, 1);
    @(posedge clk); #1;
    send(7, 0, 0, 0, 0, 0, 0);

    // load/store/imm sequence
    start_session();
    send(1, 2, 0, 5, 0, 0, 8);
    send(2, 2, 0, 0, 0, 5, 12);
    send(4, 0, 0, 1, 0, 0, 5);
    send(7, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("seq_done", done, 1); check("seq_count", word_count, 3);
    @(posedge clk); #1;

    // branch with IMEM back-pressure
    start_session(); imem_ready = 0;
    send(3, 0, 0, 0, 1, 2, 'h1FFC);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("br_we", imem_we, 1); check("br_wdata", imem_wdata, 32'hFE208EE3);
      check("br_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    imem_ready = 1;
    @(negedge clk); check("br_we4", imem_we, 1);
    @(posedge clk); #1;
    @(negedge clk); check("br_we_drop", imem_we, 0);
    @(posedge clk); #1;
    send(7, 0, 0, 0, 0, 0, 0);

    // illegal format, then recovery
    start_session();
    send(5, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check("ill_err", error, 1); check("ill_we", imem_we, 0);
    @(posedge clk); #1;
    start_session();
    @(negedge clk); check("rec_err", error, 0); check("rec_ready", in_ready, 1);
    @(posedge clk); #1;
    send(7, 0, 0, 0, 0, 0, 0);

    // overflow at DEPTH
    start_session(); imem_ready = 1;
    for (int i = 0; i < DEP; i++) send(4, 0, 0, i + 1, 0, 0, i);
    send(4, 0, 0, 9, 0, 0, 9);
    @(negedge clk);
    check("ovf_err", error, 1); check("ovf_count", word_count, DEP); check("ovf_we", imem_we, 0);
    @(posedge clk); #1;

    // reset in the middle of a write
    start_session(); imem_ready = 0;
    send(0, 0, 0, 3, 1, 2, 0);
    reset = 1;
    @(posedge clk); #1;
    check("mid_we", imem_we, 0); check("mid_addr", imem_addr, BA);
    check("mid_count", word_count, 0); check("mid_wdata", imem_wdata, 0);
    check("mid_flags", {in_ready, busy, done, error}, 0);
    model_clear();
    reset = 0;
    @(posedge clk); #1;

    // branch with odd immediate
    start_session(); imem_ready = 1;
    send(3, 0, 0, 0, 1, 2, 3);
    @(negedge clk);
`ifdef IMM_RANGE_CHECK_EN
    check("odd_err", error, 1); check("odd_we", imem_we, 0);
`else
    check("odd_we", imem_we, 1); check("odd_wdata", imem_wdata, 32'h00208163);
`endif
    @(posedge clk); #1;
    drain();
    if (exp_busy) send(7, 0, 0, 0, 0, 0, 0);

    // randomized sessions
    rand_rdy = 1;
    for (int s = 0; s < 30; s++) begin
      start_session();
      for (int b = 0; b < 6 && exp_busy; b++) begin
        int unsigned r, fmt;
        r = $urandom_range(0, 19);
        fmt = (r < 16) ? r % 5 : (r < 18) ? 7 : (r == 18) ? 5 : 6;
        send(fmt, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 8191));
        if (exp_busy && $urandom_range(0, 3) == 0) begin
          start = 1;
          @(posedge clk); #1;
          start = 0;
        end
      end
      if (exp_busy) send(7, 0, 0, 0, 0, 0, 0);
      drain();
    end
    rand_rdy = 0;
    @(posedge clk); #1;
    chk_en = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
